pwm_multichannel: RTL and testbench
===================================

# pwm_multichannel

Multi-channel PWM generator for the synthesizer's output stage. It extends the single fixed-period duty-cycle block to N channels sharing one programmable-period counter. It adds double-buffered per-channel duty registers, an edge- or center-aligned counting mode, and a period-start strobe. It sits between the note/envelope logic, which writes duty values, and the audio/LED output pins.

## Interface
- CHANNELS, 4: number of independent PWM outputs (≥1)
- WIDTH, 8: width of counter, period and duty values
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- enable  in  1  run counter; low = outputs idle low
- period  in  WIDTH  TOP value (edge mode: period = TOP+1 cycles; center mode: 2·TOP cycles)
- center  in  1  0 = edge-aligned (up-count), 1 = center-aligned (up/down)
- wr_en  in  1  write strobe for shadow duty register
- wr_ch  in  max(1,$clog2(CHANNELS))  channel index for write
- wr_duty  in  WIDTH  duty value (cycles high per up-ramp)
- pwm_out  out  CHANNELS  registered PWM outputs, bit i = channel i
- period_start  out  1  registered one-cycle pulse at start of each period

## Operation
- Registers: cnt[WIDTH], dir (0 up/1 down), top_act, mode_act, shadow[i], duty_act[i].
- Write: wr_en=1 with wr_ch<CHANNELS → shadow[wr_ch]<=wr_duty. wr_ch≥CHANNELS: ignored. Writes are accepted whether or not enable is high.
- Boundary = the cycle in which cnt will next be 0 from a running period:
  - Edge mode: cnt==top_act → cnt<=0. Otherwise cnt<=cnt+1.
  - Center mode: dir=0 and cnt==top_act → dir<=1, cnt<=cnt-1. dir=1 and cnt==1 → boundary, cnt<=0, dir<=0. top_act==0 → cnt holds 0 and every cycle is a boundary (both modes).
- At a boundary: top_act<=period, mode_act<=center, duty_act[i]<=shadow[i] for all i, dir<=0.
  - Loads use the pre-write shadow value. A write in the boundary cycle takes effect at the following boundary.
- Compare: pwm_out[i] <= (cnt < duty_act[i]) when enable, else 0.
  - duty 0 → constant low.
  - duty > top_act → constant high (edge mode).
  - Center mode: high while cnt<duty on both ramps, giving a pulse symmetric about cnt=0.
- period_start <= enable && cnt==0 && dir==0.
- enable=0:
  - cnt<=0, dir<=0, pwm_out<=0, period_start<=0.
  - top_act/mode_act/duty_act load from inputs/shadow every cycle, so new settings apply on the first enabled cycle.
- Width rules: all compares unsigned WIDTH-bit; cnt never exceeds top_act. If period is changed mid-period it is ignored until the boundary.

## Timing
- Reset values: cnt=0, dir=0, top_act=0, mode_act=0, shadow=0, duty_act=0, pwm_out=0, period_start=0.
- Reset mid-operation: all state returns to reset values on that edge; outputs low the next cycle.
- Output latency: pwm_out and period_start reflect the cnt of the previous cycle (1-cycle register).
- After enable rises (settings stable): first period_start and first active pwm_out occur 1 cycle later.
- Write → output effect: next boundary after the write cycle (at most one full period + 1 cycle).
- Edge-mode period exactly top_act+1 cycles; center-mode period exactly 2·top_act cycles (top_act≥1).

## Test plan
- CHANNELS=4, WIDTH=8, edge, period=9, duty ch0=3, enable → pwm_out[0] high 3 / low 7, repeating every 10 cycles; period_start every 10 cycles, aligned with the first high cycle.
- Duty ch1=0, ch2=255, period=9 → ch1 constantly low, ch2 constantly high; ch3 (never written) low.
- Running with ch0=3, write ch0=6 mid-period, then a second write ch0=8 exactly in a boundary cycle → current period still 3 high, next period 6 high, period after that 8 high.
- Center mode, period=4, duty ch0=2 → cnt sequence 0,1,2,3,4,3,2,1; pwm_out[0] high 3 of 8 cycles (cnt=0,1 and the trailing 1), period_start every 8 cycles.
- Write wr_ch=5 (CHANNELS=4) → no shadow changes. Deassert enable mid-period → outputs low next cycle, cnt=0. Re-enable → restarts at cnt=0 with the latest shadow values.
- Assert reset mid-period with nonzero duties → all outputs 0 next cycle. After release and enable, all channels remain low until written.

Source files
------------

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: one shared up or up/down counter drives N comparators.
// Duty values are double-buffered and only take effect at a period boundary.
module pwm_multichannel #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [WIDTH-1:0]    period,
    input  logic                center,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt, cnt_next;
    dir_t             dir, dir_next;
    logic [WIDTH-1:0] top_act;
    logic             mode_act;
    logic [WIDTH-1:0] shadow   [CHANNELS];
    logic [WIDTH-1:0] duty_act [CHANNELS];
    logic             boundary;
    logic             load;

    // Counter sequencing. In center mode the wrap to 0 happens on the down ramp
    // at cnt==1; with top_act==1 that is also the top, so the period is 0,1.
    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        boundary = 1'b0;
        if (!enable) begin
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (top_act == '0) begin
            boundary = 1'b1;
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (!mode_act) begin
            dir_next = DIR_UP;
            if (cnt == top_act) begin
                boundary = 1'b1;
                cnt_next = '0;
            end else begin
                cnt_next = cnt + ONE;
            end
        end else if (cnt == ONE && (dir == DIR_DOWN || cnt == top_act)) begin
            boundary = 1'b1;
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (dir == DIR_UP && cnt == top_act) begin
            dir_next = DIR_DOWN;
            cnt_next = cnt - ONE;
        end else if (dir == DIR_UP) begin
            cnt_next = cnt + ONE;
        end else begin
            cnt_next = cnt - ONE;
        end
    end

    // While idle the active settings track the inputs so a restart uses them at once.
    assign load = !enable || boundary;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            top_act      <= '0;
            mode_act     <= 1'b0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i]   <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            cnt <= cnt_next;
            dir <= dir_next;
            if (load) begin
                top_act  <= period;
                mode_act <= center;
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_act[i] <= shadow[i];
                end
            end
            if (wr_en && int'(wr_ch) < CHANNELS) begin
                shadow[wr_ch] <= wr_duty;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= enable && (cnt < duty_act[i]);
            end
            period_start <= enable && (cnt == '0) && (dir == DIR_UP);
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: a table of steady-state waveforms plus
// hand-written sequences for double buffering, enable, reset and out-of-range writes.
module tb_pwm_multichannel;

    localparam int CH = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          center;
    logic          wr_en;
    logic [W-1:0]  period;
    logic [W-1:0]  wr_duty;
    logic [1:0]    wr_ch;
    logic [CH-1:0] pwm_out;
    logic          period_start;
    logic [2:0]    pwm_out3;
    logic          period_start3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string                 name;
        logic [W-1:0]          period;
        logic                  center;
        logic [CH-1:0][W-1:0]  duty;
        int                    len;
        logic [CH-1:0][15:0]   pat;
    } vec_t;

    vec_t vecs [5];

    pwm_multichannel #(.CHANNELS(CH), .WIDTH(W)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period),
        .center(center), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(pwm_out), .period_start(period_start)
    );

    // Three-channel copy so that wr_ch==3 is a genuinely out-of-range index.
    pwm_multichannel #(.CHANNELS(3), .WIDTH(W)) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable), .period(period),
        .center(center), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(pwm_out3), .period_start(period_start3)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic en, input logic we,
                                 input logic [1:0] ch, input logic [W-1:0] d);
        enable  = en;
        wr_en   = we;
        wr_ch   = ch;
        wr_duty = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [CH-1:0] exp;
        int            p;
        int            d;

        // duty and pattern fields are ordered {ch3, ch2, ch1, ch0}
        vecs[0] = '{"edge_p9",   8'd9, 1'b0, {8'd0, 8'd255, 8'd0, 8'd3}, 10,
                    {16'h0000, 16'h03FF, 16'h0000, 16'h0007}};
        vecs[1] = '{"center_p4", 8'd4, 1'b1, {8'd5, 8'd0, 8'd4, 8'd2},  8,
                    {16'h00FF, 16'h0000, 16'h00EF, 16'h0083}};
        vecs[2] = '{"edge_p3",   8'd3, 1'b0, {8'd3, 8'd4, 8'd2, 8'd1},  4,
                    {16'h0007, 16'h000F, 16'h0003, 16'h0001}};
        vecs[3] = '{"center_p1", 8'd1, 1'b1, {8'd1, 8'd0, 8'd2, 8'd1},  2,
                    {16'h0001, 16'h0000, 16'h0003, 16'h0001}};
        vecs[4] = '{"edge_p0",   8'd0, 1'b0, {8'd0, 8'd1, 8'd0, 8'd1},  1,
                    {16'h0000, 16'h0001, 16'h0000, 16'h0001}};

        reset  = 1'b1;
        period = 8'd9;
        center = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
        checkOutput("reset pwm", 8'(pwm_out), 8'h00);
        checkOutput("reset period_start", 8'(period_start), 8'h00);
        checkOutput("reset pwm3", 8'(pwm_out3), 8'h00);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int c = 0; c < CH; c++) begin
                applyStimulus(1'b0, 1'b1, 2'(c), vecs[v].duty[c]);
            end
            period = vecs[v].period;
            center = vecs[v].center;
            applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
            for (int k = 0; k < 2 * vecs[v].len; k++) begin
                applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
                p = k % vecs[v].len;
                for (int c = 0; c < CH; c++) begin
                    exp[c] = vecs[v].pat[c][p];
                end
                checkOutput($sformatf("%s pwm k=%0d", vecs[v].name, k), 8'(pwm_out), 8'(exp));
                checkOutput($sformatf("%s period_start k=%0d", vecs[v].name, k),
                            8'(period_start), 8'(p == 0));
                checkOutput($sformatf("%s pwm3 k=%0d", vecs[v].name, k), 8'(pwm_out3), 8'(exp[2:0]));
            end
        end

        // Double buffering: mid-period write lands next period, boundary-cycle write one later.
        period = 8'd9;
        center = 1'b0;
        applyStimulus(1'b0, 1'b1, 2'd0, 8'd3);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
        for (int n = 0; n < 30; n++) begin
            if (n == 4)
                applyStimulus(1'b1, 1'b1, 2'd0, 8'd6);
            else if (n == 9)
                applyStimulus(1'b1, 1'b1, 2'd0, 8'd8);
            else
                applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
            d = (n < 10) ? 3 : (n < 20) ? 6 : 8;
            checkOutput($sformatf("dbuf ch0 n=%0d", n), 8'(pwm_out[0]), 8'((n % 10) < d));
            checkOutput($sformatf("dbuf period_start n=%0d", n), 8'(period_start), 8'((n % 10) == 0));
        end

        // Disable mid-period, rewrite while idle, re-enable from cnt=0.
        for (int n = 0; n < 3; n++) applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
        checkOutput("disable pwm", 8'(pwm_out), 8'h00);
        checkOutput("disable period_start", 8'(period_start), 8'h00);
        applyStimulus(1'b0, 1'b1, 2'd0, 8'd2);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
            checkOutput($sformatf("reenable ch0 k=%0d", k), 8'(pwm_out[0]), 8'(k < 2));
            checkOutput($sformatf("reenable period_start k=%0d", k), 8'(period_start), 8'(k == 0));
        end

        // Reset mid-period with ch0=2 and ch2=1 loaded.
        for (int n = 0; n < 4; n++) applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        checkOutput("midreset pwm", 8'(pwm_out), 8'h00);
        checkOutput("midreset period_start", 8'(period_start), 8'h00);
        checkOutput("midreset pwm3", 8'(pwm_out3), 8'h00);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
            checkOutput($sformatf("postreset pwm k=%0d", k), 8'(pwm_out), 8'h00);
            checkOutput($sformatf("postreset pwm3 k=%0d", k), 8'(pwm_out3), 8'h00);
        end

        // wr_ch=3 is channel 3 of the 4-channel block but out of range for the 3-channel one.
        applyStimulus(1'b0, 1'b1, 2'd3, 8'd200);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
            checkOutput($sformatf("oor pwm k=%0d", k), 8'(pwm_out), 8'h08);
            checkOutput($sformatf("oor pwm3 k=%0d", k), 8'(pwm_out3), 8'h00);
            checkOutput($sformatf("oor period_start3 k=%0d", k), 8'(period_start3), 8'(k == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
